// File: rtl/stream_link_pkg.sv
// Shared types and sizing helpers for the multi-channel stream link.
package stream_link_pkg;

  localparam int STATS_W = 32;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int calc_depth(input int addr_bits);
    return 32'd1 << addr_bits;
  endfunction

  function automatic int level_width(input int addr_bits);
    return addr_bits + 32'd1;
  endfunction

  // Low bit of channel ch inside a flat bus of width-bit slices.
  function automatic int ch_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/stream_link_fifo.sv
// One stream link channel: (DEPTH-1)-word sync-read RAM plus an output register.
// Stall counter present only when STREAM_LINK_STATS_EN is defined.
module stream_link_fifo
  import stream_link_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int ADDR_BITS    = 8,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    val_in,
  output logic                    ready_upward,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    val_out,
  input  logic                    ready_downward,
  output logic [ADDR_BITS:0]      level,
  output logic                    almost_full
`ifdef STREAM_LINK_STATS_EN
  ,
  output logic [STATS_W-1:0]      stall_cnt
`endif
);

  localparam int DEPTH = calc_depth(ADDR_BITS);
  localparam int LW    = level_width(ADDR_BITS);
  localparam logic [LW-1:0] ONE     = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] ZERO    = {LW{1'b0}};
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] SLOTS_L = LW'(DEPTH - 1);
  localparam logic [LW-1:0] AFULL_L = LW'(DEPTH - AFULL_MARGIN);
  localparam logic [ADDR_BITS-1:0] LAST_SLOT = ADDR_BITS'(DEPTH - 2);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH-1];
  logic [ADDR_BITS-1:0]    wr_ptr;
  logic [ADDR_BITS-1:0]    rd_ptr;
  logic [LW-1:0]           ram_cnt;
  logic                    wr_last;

  logic          push;
  logic          pop;
  logic          rd_en;
  op_e           op;
  logic [LW-1:0] avail;
  logic [LW-1:0] next_level;
  logic [LW-1:0] next_ram;

  // A word written at the previous edge is not yet readable, giving the two-edge first-word latency.
  always_comb begin
    push  = val_in & ready_upward;
    pop   = val_out & ready_downward;
    avail = ram_cnt - {{(LW-1){1'b0}}, wr_last};
    rd_en = (avail != ZERO) && (!val_out || ready_downward);
    op    = op_e'({push, pop});
    next_level = level;
    case (op)
      OP_PUSH: next_level = level + ONE;
      OP_POP:  next_level = level - ONE;
      OP_IDLE: next_level = level;
      OP_BOTH: next_level = level;
      default: next_level = level;
    endcase
    next_ram = ram_cnt;
    if (push && !rd_en) begin
      next_ram = ram_cnt + ONE;
    end else if (!push && rd_en) begin
      next_ram = ram_cnt - ONE;
    end else begin
      next_ram = ram_cnt;
    end
  end

  // Storage array; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy, flow-control flags and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= {ADDR_BITS{1'b0}};
      rd_ptr       <= {ADDR_BITS{1'b0}};
      ram_cnt      <= ZERO;
      wr_last      <= 1'b0;
      level        <= ZERO;
      ready_upward <= 1'b0;
      almost_full  <= 1'b0;
      val_out      <= 1'b0;
      dout         <= {PAYLOAD_BITS{1'b0}};
    end else begin
      level        <= next_level;
      ram_cnt      <= next_ram;
      wr_last      <= push;
      ready_upward <= (next_level < DEPTH_L) && (next_ram < SLOTS_L);
      almost_full  <= (next_level >= AFULL_L);
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? {ADDR_BITS{1'b0}} : wr_ptr + 1'b1;
      end
      if (rd_en) begin
        dout    <= mem[rd_ptr];
        val_out <= 1'b1;
        rd_ptr  <= (rd_ptr == LAST_SLOT) ? {ADDR_BITS{1'b0}} : rd_ptr + 1'b1;
      end else if (pop) begin
        val_out <= 1'b0;
      end
    end
  end

`ifdef STREAM_LINK_STATS_EN
  // Saturating count of cycles the head word waits on downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'h0000_0000;
    end else if (val_out && !ready_downward && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'h0000_0001;
    end
  end
`endif

endmodule

// File: rtl/stream_link_mc.sv
// NUM_CH independent valid/ready stream links on flat packed buses.
// Define STREAM_LINK_STATS_EN to add the per-channel stall_cnt output.
module stream_link_mc
  import stream_link_pkg::*;
#(
  parameter int NUM_CH             = 2,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_BRAM_ADDR_BITS = 8,
  parameter int AFULL_MARGIN       = 4
) (
  input  logic                                     ap_clk,
  input  logic                                     ap_rst_n,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0]           din,
  input  logic [NUM_CH-1:0]                        val_in,
  output logic [NUM_CH-1:0]                        ready_upward,
  output logic [NUM_CH*PAYLOAD_BITS-1:0]           dout,
  output logic [NUM_CH-1:0]                        val_out,
  input  logic [NUM_CH-1:0]                        ready_downward,
  output logic [NUM_CH*(NUM_BRAM_ADDR_BITS+1)-1:0] level,
  output logic [NUM_CH-1:0]                        almost_full
`ifdef STREAM_LINK_STATS_EN
  ,
  output logic [NUM_CH*STATS_W-1:0]                stall_cnt
`endif
);

  localparam int LW = level_width(NUM_BRAM_ADDR_BITS);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stream_link_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .ADDR_BITS    (NUM_BRAM_ADDR_BITS),
      .AFULL_MARGIN (AFULL_MARGIN)
    ) u_fifo (
      .clk            (ap_clk),
      .rst_n          (ap_rst_n),
      .din            (din[ch_lo(c, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .val_in         (val_in[c]),
      .ready_upward   (ready_upward[c]),
      .dout           (dout[ch_lo(c, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .val_out        (val_out[c]),
      .ready_downward (ready_downward[c]),
      .level          (level[ch_lo(c, LW) +: LW]),
      .almost_full    (almost_full[c])
`ifdef STREAM_LINK_STATS_EN
      ,
      .stall_cnt      (stall_cnt[ch_lo(c, STATS_W) +: STATS_W])
`endif
    );
  end

endmodule
